// File: rtl/motor_pkg.sv
// motor_pkg: command encodings, internal drive modes and width helpers for motor_drive_ctrl
package motor_pkg;

    localparam logic [2:0] CMD_COAST = 3'd0;
    localparam logic [2:0] CMD_ACC   = 3'd1;
    localparam logic [2:0] CMD_DEC   = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_FWD   = 3'd5;
    localparam logic [2:0] CMD_BACK  = 3'd6;
    localparam logic [2:0] CMD_STOP  = 3'd7;

    typedef enum logic [2:0] {COAST, RAMP_UP, RAMP_DN, CRUISE, TURN_L, TURN_R, STOPPED} mode_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic mode_e to_mode(input logic [2:0] c);
        case (c)
            CMD_ACC:            return RAMP_UP;
            CMD_DEC:            return RAMP_DN;
            CMD_FWD, CMD_BACK:  return CRUISE;
            CMD_LEFT:           return TURN_L;
            CMD_RIGHT:          return TURN_R;
            CMD_STOP:           return STOPPED;
            default:            return COAST;
        endcase
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: free-running 0..PERIOD-1 counter with a wrap strobe and a synchronous clear
module pwm_timebase
    import motor_pkg::*;
#(
    parameter int PERIOD = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic [cnt_w(PERIOD)-1:0] cnt,
    output logic                     wrap
);

    localparam int W = cnt_w(PERIOD);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt  = cnt_q;
    assign wrap = cnt_q == W'(PERIOD - 1);

    always_comb cnt_d = (clr || wrap) ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: decodes drive commands into ramped two-wheel PWM, timed turns,
// obstacle braking with hysteresis, direction enables and blinking direction LEDs
module motor_drive_ctrl
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD   = 1_000_000,
    parameter int SPEED_MAX    = 6,
    parameter int DUTY_STEP    = 100_000,
    parameter int RAMP_CYCLES  = 500,
    parameter int TURN_DUTY_HI = 800_000,
    parameter int TURN_DUTY_LO = 0,
    parameter int TURN_CYCLES  = 250_000_000,
    parameter int STOP_CM      = 25,
    parameter int CLEAR_CM     = 30,
    parameter int DIST_W       = 20,
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2:0]                       cmd,
    input  logic                             dir,
    input  logic [DIST_W-1:0]                dist_cm,
    input  logic                             dist_valid,
    output logic                             pwm_l,
    output logic                             pwm_r,
    output logic                             fwd,
    output logic                             rev,
    output logic                             green,
    output logic                             red,
    output logic                             brake,
    output logic [$clog2(SPEED_MAX+1)-1:0]   speed,
    output logic                             turn_done
);

    localparam int CW = cnt_w(PWM_PERIOD);
    localparam int DW = cnt_w(PWM_PERIOD + 1);
    localparam int SW = $clog2(SPEED_MAX + 1);
    localparam int RW = cnt_w(RAMP_CYCLES);
    localparam int TW = cnt_w(TURN_CYCLES);
    localparam int BW = cnt_w(BLINK_CYCLES);

    mode_e          mode_q, mode_d;
    logic [RW-1:0]  ramp_q, ramp_d;
    logic [SW-1:0]  speed_q, speed_d;
    logic [TW-1:0]  turn_q, turn_d;
    logic           turn_done_q, turn_done_d;
    logic           obs_q, obs_d;
    logic           fwd_q, rev_q;
    logic           pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
    logic           green_q, green_d, red_q, red_d;

    logic [CW-1:0]  pwm_cnt;
    logic [BW-1:0]  blink_cnt_unused;
    logic           pwm_wrap_unused, blink_wrap;
    logic           chg, brake_now, ramping, ramp_sw, tick, turning;
    logic [DW-1:0]  spd_duty, turn_hi, turn_lo, duty_l, duty_r;

    pwm_timebase #(.PERIOD(PWM_PERIOD)) u_frame (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .cnt  (pwm_cnt),
        .wrap (pwm_wrap_unused)
    );

    pwm_timebase #(.PERIOD(BLINK_CYCLES)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (chg),
        .cnt  (blink_cnt_unused),
        .wrap (blink_wrap)
    );

    always_comb begin
        mode_d      = to_mode(cmd);
        chg         = dir != fwd_q;
        brake_now   = obs_q & fwd_q;
        ramping     = mode_d == RAMP_UP || mode_d == RAMP_DN;
        ramp_sw     = ramping && (mode_q == RAMP_UP || mode_q == RAMP_DN) && mode_q != mode_d;
        tick        = ramping && !ramp_sw && ramp_q == RW'(RAMP_CYCLES - 1);
        ramp_d      = (!ramping || ramp_sw || tick) ? '0 : ramp_q + RW'(1);
        // direction reversal outranks braking, stop and ramp ticks
        speed_d     = chg ? '0 :
                      brake_now ? speed_q :
                      mode_d == STOPPED ? '0 :
                      (tick && mode_d == RAMP_UP && speed_q != SW'(SPEED_MAX)) ? speed_q + SW'(1) :
                      (tick && mode_d == RAMP_DN && speed_q != '0) ? speed_q - SW'(1) : speed_q;
        turning     = mode_d == TURN_L || mode_d == TURN_R;
        turn_d      = (!turning || mode_d != mode_q) ? '0 :
                      turn_q == TW'(TURN_CYCLES - 1) ? turn_q : turn_q + TW'(1);
        turn_done_d = turning && turn_d == TW'(TURN_CYCLES - 1);
        obs_d       = !dist_valid ? obs_q :
                      dist_cm <= DIST_W'(STOP_CM) ? 1'b1 :
                      dist_cm >= DIST_W'(CLEAR_CM) ? 1'b0 : obs_q;
        spd_duty    = DW'(speed_q) * DW'(DUTY_STEP);
        turn_hi     = turn_done_q ? '0 : DW'(TURN_DUTY_HI);
        turn_lo     = turn_done_q ? '0 : DW'(TURN_DUTY_LO);
        duty_l      = brake_now ? '0 : mode_d == TURN_L ? turn_hi : mode_d == TURN_R ? turn_lo :
                      (mode_d == COAST || mode_d == STOPPED) ? '0 : spd_duty;
        duty_r      = brake_now ? '0 : mode_d == TURN_L ? turn_lo : mode_d == TURN_R ? turn_hi :
                      (mode_d == COAST || mode_d == STOPPED) ? '0 : spd_duty;
        pwm_l_d     = DW'(pwm_cnt) < duty_l;
        pwm_r_d     = DW'(pwm_cnt) < duty_r;
        green_d     = !chg && dir && (green_q ^ blink_wrap);
        red_d       = !chg && !dir && (red_q ^ blink_wrap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= COAST;
            ramp_q      <= '0;
            speed_q     <= '0;
            turn_q      <= '0;
            turn_done_q <= 1'b0;
            obs_q       <= 1'b0;
            fwd_q       <= 1'b0;
            rev_q       <= 1'b0;
            pwm_l_q     <= 1'b0;
            pwm_r_q     <= 1'b0;
            green_q     <= 1'b0;
            red_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            ramp_q      <= ramp_d;
            speed_q     <= speed_d;
            turn_q      <= turn_d;
            turn_done_q <= turn_done_d;
            obs_q       <= obs_d;
            fwd_q       <= dir;
            rev_q       <= ~dir;
            pwm_l_q     <= pwm_l_d;
            pwm_r_q     <= pwm_r_d;
            green_q     <= green_d;
            red_q       <= red_d;
        end
    end

    assign pwm_l     = pwm_l_q;
    assign pwm_r     = pwm_r_q;
    assign fwd       = fwd_q;
    assign rev       = rev_q;
    assign green     = green_q;
    assign red       = red_q;
    assign brake     = obs_q & fwd_q;
    assign speed     = speed_q;
    assign turn_done = turn_done_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl: directed scenarios with a cycle model of the drive rules and literal checkpoints
module tb_motor_drive_ctrl;

    localparam int P = 10, STEP = 1, SMAX = 6, R = 4, T = 20, HI = 8, LO = 0, B = 8;
    localparam int STOP = 25, CLEAR = 30;

    logic        clk = 1'b0, rst = 1'b1, dir = 1'b1, dist_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [19:0] dist_cm = 20'd100;
    logic        pwm_l, pwm_r, fwd, rev, green, red, brake, turn_done;
    logic [2:0]  speed;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    motor_drive_ctrl #(
        .PWM_PERIOD(P), .SPEED_MAX(SMAX), .DUTY_STEP(STEP), .RAMP_CYCLES(R),
        .TURN_DUTY_HI(HI), .TURN_DUTY_LO(LO), .TURN_CYCLES(T), .STOP_CM(STOP),
        .CLEAR_CM(CLEAR), .DIST_W(20), .BLINK_CYCLES(B)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .dir(dir), .dist_cm(dist_cm), .dist_valid(dist_valid),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .fwd(fwd), .rev(rev), .green(green), .red(red),
        .brake(brake), .speed(speed), .turn_done(turn_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: frame position is edges since reset mod P, turn age is edges since entry
    int m_spd, m_ramp, m_age, m_pc, m_ticks, m_bph, dl, dr;
    bit m_obs, m_fwd, m_rev, m_pl, m_pr, m_g, m_r, m_done, brk, chg, tick;

    always @(posedge clk) begin
        if (rst) begin
            m_spd = 0; m_ramp = 0; m_age = 0; m_pc = 0; m_ticks = 0; m_bph = 0;
            m_obs = 0; m_fwd = 0; m_rev = 0; m_pl = 0; m_pr = 0; m_g = 0; m_r = 0; m_done = 0;
        end else begin
            brk = m_obs && m_fwd;
            chg = dir != m_fwd;
            dl = 0;
            dr = 0;
            if (!brk) begin
                if (cmd inside {1, 2, 5, 6}) begin dl = m_spd * STEP; dr = dl; end
                else if (cmd == 3 && !m_done) begin dl = HI; dr = LO; end
                else if (cmd == 4 && !m_done) begin dl = LO; dr = HI; end
            end
            m_pl = (m_ticks % P) < dl;
            m_pr = (m_ticks % P) < dr;
            tick = 0;
            if ((cmd == 1 || cmd == 2) && !((m_pc == 1 || m_pc == 2) && m_pc != cmd)) begin
                m_ramp++;
                if (m_ramp == R) begin m_ramp = 0; tick = 1; end
            end else m_ramp = 0;
            if (chg) m_spd = 0;
            else if (!brk) begin
                if (cmd == 7) m_spd = 0;
                else if (tick && cmd == 1) m_spd = (m_spd < SMAX) ? m_spd + 1 : SMAX;
                else if (tick && cmd == 2) m_spd = (m_spd > 0) ? m_spd - 1 : 0;
            end
            if (cmd == 3 || cmd == 4) begin
                m_age  = (cmd == m_pc) ? ((m_age < T - 1) ? m_age + 1 : T - 1) : 0;
                m_done = m_age == T - 1;
            end else begin
                m_age = 0;
                m_done = 0;
            end
            if (dist_valid && dist_cm <= STOP) m_obs = 1;
            else if (dist_valid && dist_cm >= CLEAR) m_obs = 0;
            if (chg) begin m_bph = 0; m_g = 0; m_r = 0; end
            else if (m_bph == B - 1) begin
                m_bph = 0;
                if (dir) m_g = !m_g; else m_r = !m_r;
            end else m_bph++;
            m_fwd = dir;
            m_rev = !dir;
            m_pc = cmd;
            m_ticks++;
        end
        #1;
        chk("m_pwm_l", pwm_l, m_pl);
        chk("m_pwm_r", pwm_r, m_pr);
        chk("m_fwd", fwd, m_fwd);
        chk("m_rev", rev, m_rev);
        chk("m_green", green, m_g);
        chk("m_red", red, m_r);
        chk("m_brake", brake, m_obs && m_fwd);
        chk("m_speed", speed, m_spd);
        chk("m_turn_done", turn_done, m_done);
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_hi(output int l, output int r);
        l = 0;
        r = 0;
        repeat (10) begin
            @(negedge clk);
            l += int'(pwm_l);
            r += int'(pwm_r);
        end
    endtask

    task automatic pulse(input int d);
        dist_cm = 20'(d);
        dist_valid = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
    endtask

    int hl, hr;

    initial begin
        run(3);
        chk("reset_speed", speed, 0);
        chk("reset_fwd", fwd, 0);
        chk("reset_pwm_l", pwm_l, 0);
        chk("reset_turn_done", turn_done, 0);
        rst = 1'b0;
        // ramp up, saturate, ramp down, stop
        cmd = 3'd1;
        run(4);  chk("ramp_s1", speed, 1);
        run(4);  chk("ramp_s2", speed, 2);
        run(32); chk("ramp_sat", speed, 6);
        count_hi(hl, hr); chk("acc_duty_l", hl, 6); chk("acc_duty_r", hr, 6);
        cmd = 3'd2;
        run(40); chk("dec_floor", speed, 0);
        count_hi(hl, hr); chk("dec_duty_l", hl, 0);
        cmd = 3'd7;
        run(2);  chk("stop_speed", speed, 0);
        // hold across fwd and coast
        cmd = 3'd1;
        run(12); chk("ramp_s3", speed, 3);
        cmd = 3'd5;
        count_hi(hl, hr); chk("fwd_duty_l", hl, 3); chk("fwd_duty_r", hr, 3); chk("fwd_hold", speed, 3);
        cmd = 3'd0;
        count_hi(hl, hr); chk("coast_duty_l", hl, 0); chk("coast_speed", speed, 3);
        cmd = 3'd7;
        run(1);  chk("stop_clear", speed, 0);
        // turns
        cmd = 3'd3;
        count_hi(hl, hr); chk("left_duty_l", hl, 8); chk("left_duty_r", hr, 0);
        run(9);  chk("turn_not_done", turn_done, 0);
        run(1);  chk("turn_done", turn_done, 1);
        count_hi(hl, hr); chk("done_pwm_l", hl, 0); chk("done_pwm_r", hr, 0);
        cmd = 3'd4;
        run(1);  chk("turn_restart", turn_done, 0);
        count_hi(hl, hr); chk("right_duty_l", hl, 0); chk("right_duty_r", hr, 8);
        // obstacle hysteresis
        cmd = 3'd1;
        run(16); chk("ramp_s4", speed, 4);
        cmd = 3'd5;
        pulse(24); chk("brake_on", brake, 1);
        count_hi(hl, hr); chk("brake_pwm_l", hl, 0); chk("brake_pwm_r", hr, 0);
        pulse(27); chk("brake_hold", brake, 1);
        pulse(30); chk("brake_off", brake, 0);
        count_hi(hl, hr); chk("resume_duty_l", hl, 4); chk("brake_speed", speed, 4);
        dir = 1'b0;
        run(1);  chk("rev_speed", speed, 0); chk("rev_rev", rev, 1);
        pulse(24); chk("rev_no_brake", brake, 0);
        cmd = 3'd1;
        run(8);  chk("rev_ramp", speed, 2);
        cmd = 3'd5;
        count_hi(hl, hr); chk("rev_duty_l", hl, 2);
        // reversal and LED blink
        pulse(100);
        dir = 1'b1;
        run(1);  chk("fwd_again", fwd, 1);
        cmd = 3'd1;
        run(20); chk("ramp_s5", speed, 5);
        cmd = 3'd5;
        dir = 1'b0;
        run(1);
        chk("flip_speed", speed, 0); chk("flip_fwd", fwd, 0); chk("flip_rev", rev, 1);
        chk("flip_green", green, 0); chk("flip_red", red, 0);
        run(7);  chk("red_wait", red, 0);
        run(1);  chk("red_on", red, 1); chk("green_idle", green, 0);
        run(8);  chk("red_off", red, 0);
        // reset mid-turn
        dir = 1'b1;
        cmd = 3'd3;
        run(11);
        rst = 1'b1;
        run(1);
        chk("rst_pwm_l", pwm_l, 0); chk("rst_pwm_r", pwm_r, 0); chk("rst_fwd", fwd, 0);
        chk("rst_rev", rev, 0); chk("rst_green", green, 0); chk("rst_red", red, 0);
        chk("rst_brake", brake, 0); chk("rst_speed", speed, 0); chk("rst_turn_done", turn_done, 0);
        rst = 1'b0;
        run(19); chk("post_rst_turn", turn_done, 0);
        run(1);  chk("post_rst_done", turn_done, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motor_drive_ctrl.md
Name: motor_drive_ctrl

Overview:
Parametrised two-motor drive controller: the next generation of the car's command-to-PWM block.
- Decodes the 3-bit drive command into left/right PWM with ramped speed, timed differential turns, direction outputs and blinking direction LEDs.
- New over the previous generation: parametrised PWM period, speed steps, ramp rate, turn duties and turn time; obstacle braking with hysteresis and a distance-valid strobe; speed retained across forward/back commands; safe speed clear on direction reversal.
- Sits between the input synchronisers / ultrasonic ranger and the motor driver pins.

Parameters:
PWM_PERIOD, 1_000_000, PWM frame length in clk cycles
SPEED_MAX, 6, highest speed level
DUTY_STEP, 100_000, compare value per speed level; SPEED_MAX*DUTY_STEP <= PWM_PERIOD
RAMP_CYCLES, 500, cycles per speed level change while accelerating/decelerating
TURN_DUTY_HI, 800_000, outer-wheel compare value during a turn
TURN_DUTY_LO, 0, inner-wheel compare value during a turn
TURN_CYCLES, 250_000_000, turn duration in cycles
STOP_CM, 25, obstacle asserted when distance <= STOP_CM
CLEAR_CM, 30, obstacle released when distance >= CLEAR_CM; CLEAR_CM > STOP_CM
DIST_W, 20, distance width
BLINK_CYCLES, 50_000_000, LED toggle interval

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd  in  3  drive command, pre-synchronised: 0 coast, 1 acc, 2 dec, 3 left, 4 right, 5 fwd, 6 back, 7 stop
dir  in  1  1 = forward, 0 = reverse, pre-synchronised
dist_cm  in  DIST_W  latest ultrasonic distance
dist_valid  in  1  one-cycle strobe qualifying dist_cm
pwm_l  out  1  left motor PWM
pwm_r  out  1  right motor PWM
fwd  out  1  forward enable
rev  out  1  reverse enable
green  out  1  forward LED, blinking
red  out  1  reverse LED, blinking
brake  out  1  obstacle braking active
speed  out  $clog2(SPEED_MAX+1)  current speed level
turn_done  out  1  turn time expired, held until cmd leaves 3/4

Behaviour:
Reset
- All outputs and registers are 0 on rst.

Clock and command
- One clock domain.
- cmd is sampled every cycle; no handshake. The last command wins.

PWM
- Shared frame counter runs 0..PWM_PERIOD-1 and wraps, free-running.
- pwm_x is registered from (cnt < duty_x): 1-cycle latency from counter to pin.
- duty = 0 gives a constant low output.

Speed
- acc: ramp counter increments each cycle; at RAMP_CYCLES-1 it clears and speed increments, saturating at SPEED_MAX.
- dec: same ramp counter; speed decrements, saturating at 0.
- Ramp counter clears whenever cmd is not 1 or 2, and on a 1<->2 switch.
- fwd/back: hold speed; duty_l = duty_r = speed*DUTY_STEP.
- acc/dec: both outputs also use speed*DUTY_STEP.
- coast (0): PWM 0, speed held.
- stop (7): PWM 0, speed cleared.
- Turn commands hold speed.

Turn
- left: pwm_l uses TURN_DUTY_HI, pwm_r uses TURN_DUTY_LO. right: mirrored.
- Turn counter clears on entry to 3/4 and on a 3<->4 switch.
- At TURN_CYCLES-1: turn_done=1 and both PWMs are forced to 0 until cmd changes.

Direction
- fwd = dir, rev = ~dir, registered.
- A dir change clears speed to 0 in the same cycle the change is registered, clears the blink counter, and clears both LEDs.

Obstacle
- Set on dist_valid && dist_cm <= STOP_CM.
- Cleared on dist_valid && dist_cm >= CLEAR_CM.
- Between the two thresholds, or with dist_valid=0: hold.
- brake = obstacle && dir. While brake=1, both PWMs are forced to 0 in all commands and speed is held.
- Reverse motion is unaffected by the obstacle.

LEDs
- Blink counter wraps at BLINK_CYCLES-1.
- On wrap: green toggles if dir=1, else red toggles. The inactive LED is held at 0.

Simultaneous events
- rst beats everything.
- Brake forcing beats turn and speed PWM.
- A dir change in the same cycle as a ramp tick: speed clear wins.

Decomposition:
- Package motor_pkg holds:
  - cmd encodings as named constants
  - internal mode enum: COAST, RAMP_UP, RAMP_DN, CRUISE, TURN_L, TURN_R, STOPPED
  - width helper functions
- Sub-module pwm_timebase: frame counter plus wrap strobe. Reused by the blink divider with a different period.

Test Plan:
Bench parameters for all scenarios: PWM_PERIOD=10, DUTY_STEP=1, SPEED_MAX=6, RAMP_CYCLES=4, TURN_CYCLES=20, TURN_DUTY_HI=8, TURN_DUTY_LO=0, BLINK_CYCLES=8, STOP_CM=25, CLEAR_CM=30.
1. Ramp: dir=1, cmd=1 for 40 cycles -> speed steps 1..6 every 4 cycles, then holds at 6; pwm_l high 6 of every 10 cycles. cmd=2 for 40 cycles -> speed 0, PWM low. cmd=7 -> speed 0.
2. Hold: ramp to 3, then cmd=5 -> speed stays 3, duty 3/10. cmd=0 -> PWM 0, speed 3.
3. Turn: cmd=3 -> pwm_l 8/10, pwm_r 0. After 20 cycles turn_done=1 and both PWMs 0. Switch to cmd=4 -> counter restarts, turn_done=0, mirrored duties.
4. Hysteresis: at speed 4, dist 24 valid -> brake=1, PWMs 0. Dist 27 -> still braking. Dist 30 -> brake=0, duty 4/10 resumes. Same stimulus with dir=0 -> brake stays 0.
5. Reversal: speed 5, toggle dir -> speed 0 next cycle, fwd/rev swap, LEDs 0; red toggles every 8 cycles, green stays 0.
6. Reset mid-turn: assert rst during cmd=3 at turn count 10 -> every output 0 on the next edge; deassert with cmd=3 held -> turn counter restarts from 0.
